alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the existing single-cycle 32-bit ALU.
- Keeps the 5-bit opcode map from the current decoder.
- Adds valid/ready flow control, a persistent carry register for add-with-carry and subtract-with-borrow, result flags, and illegal-opcode reporting.
- Sits between the register-read stage and writeback of the processor datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- OPW, 5, opcode width; fixed to match the decoder map.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  block enable; when 0, in_ready=0 and no new op is accepted.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- opcode  in  OPW  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- out_carry  out  1  carry / no-borrow of this op.
- out_zero  out  1  out == 0.
- out_ovf  out  1  signed overflow (add/sub family only, else 0).
- out_illegal  out  1  opcode not implemented; out forced to 0.

Behaviour:
- Opcode map:
  - 0 ADD: a+b, cin=0.
  - 1 ADDC: a+b+carry_q.
  - 2 SUB: a+~b+1.
  - 3 SUBB: a+~b+carry_q.
  - 4 MUL: see Optional Feature.
  - 5-7 float ops: illegal.
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR.
  - 14 NOT: ~a, b ignored.
  - 15 NEG: ~a+1.
  - 16-31: illegal.
- Carry convention: carry=1 means no borrow on subtract. NEG sets out_carry = (a==0).
- Logical ops: out_carry=0, out_ovf=0.
- Stage 1 (S1) registers opcode, a, b on handshake.
- Stage 2 (S2) computes from S1 and registers out and flags.
- Latency: exactly 2 cycles from accept to out_valid when out_ready=1. Throughput is 1 op/cycle.
- Backpressure:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or draining.
  - in_ready = enable && (!s1_valid || s1_advance).
  - All outputs are stable while out_valid && !out_ready.
- carry_q:
  - Internal register, reset 0.
  - Updated only when an op 0-3 or 15 moves S1->S2, so a back-to-back ADD then ADDC chains correctly without a bubble.
  - Illegal and logical ops leave it unchanged.
- ovf: for add, set when the sign of a equals the sign of the effective b (b for add, ~b for sub) and differs from the result sign.
- Width: internal sum is WIDTH+1 bits; out = sum[WIDTH-1:0], out_carry = sum[WIDTH].
- Illegal op: passes through the pipeline normally with out=0, out_illegal=1, other flags 0, carry_q untouched.
- Reset (async, any time, including mid-stall): s1_valid=0, out_valid=0, out=0, all flags 0, carry_q=0. in_ready reflects enable on the first cycle after release.
- enable dropping mid-operation: blocks new accepts only; ops already in flight drain normally.
- Simultaneous S2 drain and new accept: both occur in the same cycle, with no bubble.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 4 computes the low WIDTH bits of a*b (unsigned) in S2. out_carry=1 iff the high half is nonzero; ovf=0. Latency unchanged.
- Undefined: opcode 4 is illegal (out=0, out_illegal=1). No multiplier is inferred.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_NEG).
  - NUM_OPS.
  - is_arith / is_logic / is_legal functions used by both RTL and bench.
- One sub-module, alu_pipe_exec: combinational WIDTH-parametrised execute unit (opcode, a, b, cin -> result, carry, ovf, illegal). Instantiated in S2; the carry_q update logic taps its carry output.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF b=0x1, then ADDC a=0 b=0 back-to-back -> out=0x0 carry=1 zero=1, then out=0x1 carry=0, on consecutive cycles 2 and 3 after the first accept.
- SUB a=5 b=7 -> out=0xFFFFFFFE carry=0; following SUBB a=10 b=3 -> out=0x6.
- ADD a=0x7FFFFFFF b=1 -> out=0x80000000 ovf=1. Opcode 9 OR a=0xF0 b=0x0F -> 0xFF, ovf=0.
- Hold out_ready=0 for 5 cycles with 3 ops offered -> exactly 2 accepted, outputs stable; release -> results emerge in order with no loss or duplication.
- Opcode 6 and opcode 20 -> out=0, out_illegal=1, carry_q unchanged. Opcode 4 with a=3 b=4 -> illegal without the macro, out=12 with ALU_PIPE_MUL_EN.
- Assert rst mid-stall with both stages full -> out_valid=0 and carry_q=0 immediately; subsequent ADDC 1+1 -> out=2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode map and opcode classification helpers for alu_pipe.
// Used by the RTL (alu_pipe, alu_pipe_exec) and by the testbench.
// Configuration macro: ALU_PIPE_MUL_EN (opcode 4 becomes a legal multiply).
package alu_pkg;

   localparam int unsigned OP_W    = 5;
   localparam int unsigned NUM_OPS = 1 << OP_W;

   localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] OP_ADDC = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OP_W-1:0] OP_SUBB = 5'd3;
   localparam logic [OP_W-1:0] OP_MUL  = 5'd4;
   localparam logic [OP_W-1:0] OP_AND  = 5'd8;
   localparam logic [OP_W-1:0] OP_OR   = 5'd9;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd10;
   localparam logic [OP_W-1:0] OP_NAND = 5'd11;
   localparam logic [OP_W-1:0] OP_NOR  = 5'd12;
   localparam logic [OP_W-1:0] OP_XNOR = 5'd13;
   localparam logic [OP_W-1:0] OP_NOT  = 5'd14;
   localparam logic [OP_W-1:0] OP_NEG  = 5'd15;

   // Add/sub family: the ops that produce a carry and update the carry register.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op <= OP_SUBB) || (op == OP_NEG);
   endfunction

   function automatic logic is_logic(input logic [OP_W-1:0] op);
      return (op >= OP_AND) && (op <= OP_NOT);
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
`ifdef ALU_PIPE_MUL_EN
      return is_arith(op) || is_logic(op) || (op == OP_MUL);
`else
      return is_arith(op) || is_logic(op);
`endif
   endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: combinational execute unit of alu_pipe.
// Ports:
//   i_op      opcode (alu_pkg map)
//   i_a, i_b  operands, WIDTH bits
//   i_cin     persistent carry for ADDC/SUBB
//   o_result  result (0 for illegal opcodes)
//   o_carry   carry / no-borrow; (|high half) for MUL
//   o_ovf     signed overflow, add/sub family only
//   o_illegal high when the opcode is outside the supported map
// Macro ALU_PIPE_MUL_EN enables opcode 4 (low half of unsigned a*b).
module alu_pipe_exec
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_ovf,
   output logic             o_illegal
);

   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;
   logic             w_c;
   logic [WIDTH:0]   w_sum;
   logic             w_add_ovf;
`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] w_prod;
   assign w_prod = i_a * i_b;
`endif

   // Single shared adder: subtraction is a + ~b + cin, NEG is 0 + ~a + 1.
   always_comb begin
      w_opa = i_a;
      w_opb = i_b;
      w_c   = 1'b0;
      case (i_op)
         OP_ADDC: w_c = i_cin;
         OP_SUB: begin
            w_opb = ~i_b;
            w_c   = 1'b1;
         end
         OP_SUBB: begin
            w_opb = ~i_b;
            w_c   = i_cin;
         end
         OP_NEG: begin
            w_opa = '0;
            w_opb = ~i_a;
            w_c   = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_sum     = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_c};
   assign w_add_ovf = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != w_opa[WIDTH-1]);

   always_comb begin
      o_result  = '0;
      o_carry   = 1'b0;
      o_ovf     = 1'b0;
      o_illegal = 1'b0;
      case (i_op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_NEG: begin
            o_result = w_sum[WIDTH-1:0];
            o_carry  = w_sum[WIDTH];
            o_ovf    = w_add_ovf;
         end
`ifdef ALU_PIPE_MUL_EN
         OP_MUL: begin
            o_result = w_prod[WIDTH-1:0];
            o_carry  = |w_prod[2*WIDTH-1:WIDTH];
         end
`endif
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NAND: o_result = ~(i_a & i_b);
         OP_NOR:  o_result = ~(i_a | i_b);
         OP_XNOR: o_result = ~(i_a ^ i_b);
         OP_NOT:  o_result = ~i_a;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready flow control.
// S1 registers opcode/operands on accept; S2 executes and registers result + flags.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              block enable, gates in_ready
//   in_valid/in_ready   input handshake; opcode, a, b
//   out_valid/out_ready output handshake; out, out_carry, out_zero, out_ovf, out_illegal
// Macro ALU_PIPE_MUL_EN enables opcode 4 (multiply); otherwise it is illegal.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_illegal
);

   logic             r_s1_valid;
   logic [OPW-1:0]   r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_carry_q;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic             r_out_carry;
   logic             r_out_zero;
   logic             r_out_ovf;
   logic             r_out_illegal;

   logic             w_s2_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_ex_result;
   logic             w_ex_carry;
   logic             w_ex_ovf;
   logic             w_ex_illegal;

   // S2 can take a new entry when empty or when its current result drains this cycle.
   assign w_s2_ready = !r_out_valid || out_ready;
   assign in_ready   = enable && !rst && (!r_s1_valid || w_s2_ready);
   assign w_accept   = in_valid && in_ready;

   alu_pipe_exec #(
      .WIDTH(WIDTH)
   ) u_exec (
      .i_op     (r_s1_op),
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .i_cin    (r_carry_q),
      .o_result (w_ex_result),
      .o_carry  (w_ex_carry),
      .o_ovf    (w_ex_ovf),
      .o_illegal(w_ex_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (!r_s1_valid || w_s2_ready) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_op <= opcode;
            r_s1_a  <= a;
            r_s1_b  <= b;
         end
      end
   end

   // carry_q updates as the op enters S2, so an ADDC right behind an ADD
   // in S1 sees the fresh carry with no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out         <= '0;
         r_out_carry   <= 1'b0;
         r_out_zero    <= 1'b0;
         r_out_ovf     <= 1'b0;
         r_out_illegal <= 1'b0;
         r_carry_q     <= 1'b0;
      end else if (w_s2_ready) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out         <= w_ex_result;
            r_out_carry   <= w_ex_carry;
            r_out_zero    <= !w_ex_illegal && (w_ex_result == '0);
            r_out_ovf     <= w_ex_ovf;
            r_out_illegal <= w_ex_illegal;
            if (is_arith(r_s1_op)) begin
               r_carry_q <= w_ex_carry;
            end
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out         = r_out;
   assign out_carry   = r_out_carry;
   assign out_zero    = r_out_zero;
   assign out_ovf     = r_out_ovf;
   assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32).
// The driver pushes the expected response when an op is accepted; a monitor
// process pops and compares whenever a result is handed off.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] out;
      logic         c;
      logic         z;
      logic         v;
      logic         ill;
      bit           lat;
      int unsigned  due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         out_carry;
   logic         out_zero;
   logic         out_ovf;
   logic         out_illegal;

   int unsigned cyc = 0;
   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   exp_t        q[$];

   alu_pipe #(
      .WIDTH(W),
      .OPW  (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_ovf    (out_ovf),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic exp_t mk(input logic [W-1:0] o, input logic c, z, v, ill, input bit lat);
      exp_t e;
      e.out = o; e.c = c; e.z = z; e.v = v; e.ill = ill; e.lat = lat; e.due = 0;
      return e;
   endfunction

   // Offer one op until accepted (bounded); expected result queued on accept.
   task automatic send(input logic [4:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib, input exp_t e);
      bit acc = 0;
      int unsigned n = 0;
      exp_t ee = e;
      in_valid = 1'b1; opcode = op; a = ia; b = ib;
      while (!acc && n < 50) begin
         @(negedge clk);
         if (in_ready) begin
            ee.due = cyc + 2;
            q.push_back(ee);
            acc = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   exp_t e_mul;
   exp_t e_ill;

   initial begin
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; a = '0; b = '0;

      // Monitor: compare each handed-off result against the scoreboard head.
      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("spurious_output", {32'd0, out}, 64'd0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("result", {28'd0, out, out_carry, out_zero, out_ovf, out_illegal},
                        {28'd0, e.out, e.c, e.z, e.v, e.ill});
                  if (e.lat) check("latency", 64'(cyc), 64'(e.due));
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out", {32'd0, out}, 64'd0);
      check("reset_flags", {60'd0, out_carry, out_zero, out_ovf, out_illegal}, 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Carry chain, back to back.
      send(OP_ADD,  32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 1, 0, 0, 1));
      send(OP_ADDC, 32'h0,         32'h0, mk(32'h1, 0, 0, 0, 0, 1));
      // Borrow chain.
      send(OP_SUB,  32'd5,  32'd7, mk(32'hFFFF_FFFE, 0, 0, 0, 0, 0));
      send(OP_SUBB, 32'd10, 32'd3, mk(32'h6, 1, 0, 0, 0, 0));
      // Overflow and logical ops.
      send(OP_ADD,  32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 0, 1, 0, 0));
      send(OP_OR,   32'hF0, 32'h0F, mk(32'hFF, 0, 0, 0, 0, 0));
      send(OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, mk(32'hF00F_F00F, 0, 0, 0, 0, 0));
      send(OP_NEG,  32'h0, 32'h1234, mk(32'h0, 1, 1, 0, 0, 0));
      send(OP_NEG,  32'd5, 32'h0, mk(32'hFFFF_FFFB, 0, 0, 0, 0, 0));
      send(OP_NOT,  32'h0, 32'h5, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 0));

      // Illegal ops leave carry_q (set to 1 here) untouched.
      e_ill = mk(32'h0, 0, 0, 0, 1, 0);
`ifdef ALU_PIPE_MUL_EN
      e_mul = mk(32'd12, 0, 0, 0, 0, 0);
`else
      e_mul = e_ill;
`endif
      if (!is_legal(OP_MUL)) e_mul = e_ill;
      send(OP_ADD,  32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 1, 0, 0, 0));
      send(5'd6,    32'h55, 32'h66, e_ill);
      send(5'd20,   32'h77, 32'h88, e_ill);
      send(OP_MUL,  32'd3, 32'd4, e_mul);
      send(OP_ADDC, 32'h0, 32'h0, mk(32'h1, 0, 0, 0, 0, 0));

      // Enable drop: in-flight op drains, new offers blocked.
      send(OP_AND, 32'hFF, 32'h3C, mk(32'h3C, 0, 0, 0, 0, 0));
      enable = 1'b0;
      in_valid = 1'b1; opcode = OP_XOR; a = 32'h1; b = 32'h3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("enable_low_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      enable = 1'b1;
      send(OP_XOR, 32'h1, 32'h3, mk(32'h2, 0, 0, 0, 0, 0));
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: 2 of 3 accepted, outputs hold, then ordered release.
      out_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd2, mk(32'd3, 0, 0, 0, 0, 0));
      send(OP_SUB, 32'd9, 32'd4, mk(32'd5, 1, 0, 0, 0, 0));
      in_valid = 1'b1; opcode = OP_AND; a = 32'hF0; b = 32'h3C;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out", {31'd0, out_valid, out}, {31'd0, 1'b1, 32'd3});
         @(posedge clk); #1;
      end
      check("stall_queue_depth", 64'(q.size()), 64'd2);
      out_ready = 1'b1;
      send(OP_AND, 32'hF0, 32'h3C, mk(32'h30, 0, 0, 0, 0, 0));
      repeat (4) @(posedge clk);
      #1;

      // Reset with both stages full and carry_q = 1.
      out_ready = 1'b0;
      send(OP_ADD, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 1, 0, 0, 0));
      send(OP_OR,  32'h1, 32'h2, mk(32'h3, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out", {32'd0, out}, 64'd0);
      check("midrst_flags", {60'd0, out_carry, out_zero, out_ovf, out_illegal}, 64'd0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      send(OP_ADDC, 32'd1, 32'd1, mk(32'd2, 0, 0, 0, 0, 0));

      // Drain with a bound.
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 64'(q.size()), 64'd0);
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
